counter_ctrl: RTL

- Upstream control stage for the 8-bit up/down counter.
- Converts three raw push-button inputs into the counter's `enable` and `direction` controls:
  - two-flop synchronisation;
  - per-button debounce;
  - rising-edge press detection;
  - a three-state run FSM.
- `enable` and `direction` connect directly to the counter's same-named inputs.
- Shares `clk` and `rst` with the counter.

---
 rtl/counter_ctrl.sv | 112 +++++++++++
 1 files changed

// File: rtl/counter_ctrl.sv
// Push-button front end for the up/down counter: synchronise, debounce and edge-detect
// three buttons, then drive enable/direction from a three-state run FSM. Optional: CTRL_TOGGLE_EN.
module counter_ctrl #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_stop,
  output logic       enable,
  output logic       direction,
  output logic [1:0] state
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_STOPPED  = 2'b00,
    ST_RUN_UP   = 2'b01,
    ST_RUN_DOWN = 2'b10
  } state_t;

  // Bit order: 0 = up, 1 = down, 2 = stop.
  logic [2:0] w_btn_raw;
  logic [2:0] w_press;

  assign w_btn_raw = {btn_stop, btn_down, btn_up};

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_btn
      logic          r_sync1;
      logic          r_sync2;
      logic          r_db;
      logic          r_db_d;
      logic [CW-1:0] r_cnt;

      always_ff @(posedge clk) begin
        if (rst) begin
          r_sync1 <= 1'b0;
          r_sync2 <= 1'b0;
          r_db    <= 1'b0;
          r_db_d  <= 1'b0;
          r_cnt   <= '0;
        end else begin
          r_sync1 <= w_btn_raw[gi];
          r_sync2 <= r_sync1;
          r_db_d  <= r_db;
          // Level only flips after DEBOUNCE_CYCLES consecutive disagreeing samples.
          if (r_sync2 == r_db) begin
            r_cnt <= '0;
          end else if (r_cnt == CNT_LAST) begin
            r_db  <= r_sync2;
            r_cnt <= '0;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
      end

      assign w_press[gi] = r_db & ~r_db_d;
    end
  endgenerate

  state_t r_state;
  logic   r_enable;
  logic   r_direction;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_STOPPED;
      r_enable    <= 1'b0;
      r_direction <= 1'b1;
    end else if (w_press[2]) begin
      r_state  <= ST_STOPPED;
      r_enable <= 1'b0;
    end else if (w_press[1]) begin
      if (r_state == ST_RUN_DOWN) begin
`ifdef CTRL_TOGGLE_EN
        r_state  <= ST_STOPPED;
        r_enable <= 1'b0;
`else
        r_state  <= r_state;
`endif
      end else begin
        r_state     <= ST_RUN_DOWN;
        r_enable    <= 1'b1;
        r_direction <= 1'b0;
      end
    end else if (w_press[0]) begin
      if (r_state == ST_RUN_UP) begin
`ifdef CTRL_TOGGLE_EN
        r_state  <= ST_STOPPED;
        r_enable <= 1'b0;
`else
        r_state  <= r_state;
`endif
      end else begin
        r_state     <= ST_RUN_UP;
        r_enable    <= 1'b1;
        r_direction <= 1'b1;
      end
    end
  end

  assign enable    = r_enable;
  assign direction = r_direction;
  assign state     = r_state;

endmodule
